// File: rtl/rx_packet_sequencer.sv
// Receive-side packet sequencer: tracks SYNC/PID/payload framing from strobed bits and eop.
// Optional PID_CHECK_EN macro enables the PID complement-nibble check before decode.
module rx_packet_sequencer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       shift_strobe,
  input  logic       rcv_bit,
  input  logic       eop,
  output logic       sync_shift_enable,
  output logic       pid_shift_enable,
  output logic       crc5_shift_enable,
  output logic       crc16_shift_enable,
  output logic       data_shift_enable,
  output logic       rcving,
  output logic       r_error,
  output logic       pkt_done,
  output logic [3:0] pid
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_TOKEN,
    ST_DATA,
    ST_WAIT_EOP,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    PK_TOKEN,
    PK_DATA,
    PK_HANDSHAKE,
    PK_INVALID
  } pid_kind_t;

  localparam logic [7:0]  SYNC_PATTERN = 8'h80;
  localparam logic [13:0] BYTE_BITS    = 14'd8;
  localparam logic [13:0] TOKEN_BITS   = 14'd16;
  localparam logic [13:0] DATA_MIN     = 14'd16;
  localparam logic [13:0] DATA_LIMIT   = 14'd8201;

  state_t      state, state_next;
  logic [7:0]  shift_reg, shift_next;
  logic [13:0] bit_cnt, cnt_upd;
  logic        err_flag, err_next;
  logic [3:0]  pid_q, pid_next;
  logic        byte_done;
  logic        pid_check_ok;
  pid_kind_t   pid_kind;

  function automatic pid_kind_t decode_pid(input logic [3:0] nibble);
    case (nibble)
      4'b0001, 4'b1001, 4'b1101, 4'b0101: return PK_TOKEN;
      4'b0011, 4'b1011:                   return PK_DATA;
      4'b0010, 4'b1010, 4'b1110:          return PK_HANDSHAKE;
      default:                            return PK_INVALID;
    endcase
  endfunction

  // Strobe is folded in before any eop decision, so eop sees the updated count.
  always_comb begin
    shift_next = shift_reg;
    cnt_upd    = bit_cnt;
    if (state != ST_IDLE && shift_strobe) begin
      shift_next = {rcv_bit, shift_reg[7:1]};
      cnt_upd    = bit_cnt + 14'd1;
    end
  end

  assign byte_done = shift_strobe && (cnt_upd == BYTE_BITS);
  assign pid_kind  = decode_pid(shift_next[3:0]);

`ifdef PID_CHECK_EN
  assign pid_check_ok = (shift_next[7:4] == ~shift_next[3:0]);
`else
  assign pid_check_ok = 1'b1;
`endif

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    err_next   = err_flag;
    pid_next   = pid_q;

    case (state)
      ST_IDLE: begin
        if (d_edge) begin
          state_next = ST_SYNC;
          err_next   = 1'b0;
        end
      end

      ST_SYNC: begin
        if (eop)
          state_next = ST_ERROR;
        else if (byte_done)
          state_next = (shift_next == SYNC_PATTERN) ? ST_PID : ST_ERROR;
      end

      ST_PID: begin
        if (byte_done)
          pid_next = shift_next[3:0];
        if (eop)
          state_next = ST_ERROR;
        else if (byte_done) begin
          if (!pid_check_ok)
            state_next = ST_ERROR;
          else begin
            case (pid_kind)
              PK_TOKEN:     state_next = ST_TOKEN;
              PK_DATA:      state_next = ST_DATA;
              PK_HANDSHAKE: state_next = ST_WAIT_EOP;
              default:      state_next = ST_ERROR;
            endcase
          end
        end
      end

      ST_TOKEN: begin
        // A 17th strobe is fatal even if eop arrives in the same cycle.
        if (shift_strobe && bit_cnt == TOKEN_BITS)
          state_next = ST_ERROR;
        else if (eop)
          state_next = (cnt_upd == TOKEN_BITS) ? ST_DONE : ST_ERROR;
      end

      ST_DATA: begin
        if (eop)
          state_next = (cnt_upd[2:0] == 3'd0 && cnt_upd >= DATA_MIN) ? ST_DONE : ST_ERROR;
        else if (cnt_upd == DATA_LIMIT)
          state_next = ST_ERROR;
      end

      ST_WAIT_EOP: begin
        if (shift_strobe)
          state_next = ST_ERROR;
        else if (eop)
          state_next = ST_DONE;
      end

      ST_DONE:  state_next = ST_IDLE;

      ST_ERROR: begin
        if (eop)
          state_next = ST_IDLE;
      end

      default:  state_next = ST_IDLE;
    endcase

    if (state_next == ST_ERROR)
      err_next = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      err_flag  <= 1'b0;
      pid_q     <= 4'h0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= (state_next != state) ? '0 : cnt_upd;
      err_flag  <= err_next;
      pid_q     <= pid_next;
    end
  end

  always_comb begin
    sync_shift_enable  = (state == ST_SYNC);
    pid_shift_enable   = (state == ST_PID);
    crc5_shift_enable  = (state == ST_TOKEN);
    crc16_shift_enable = (state == ST_DATA);
    data_shift_enable  = (state == ST_DATA);
    rcving             = (state != ST_IDLE);
    pkt_done           = (state == ST_DONE);
  end

  assign r_error = err_flag;
  assign pid     = pid_q;

endmodule

// File: tb/tb_rx_packet_sequencer.sv
// Self-checking bench for rx_packet_sequencer: directed and randomized packets
// compared against a packet-level reference model built from the framing rules.
module tb_rx_packet_sequencer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_edge, shift_strobe, rcv_bit, eop;
  logic       sync_shift_enable, pid_shift_enable, crc5_shift_enable;
  logic       crc16_shift_enable, data_shift_enable;
  logic       rcving, r_error, pkt_done;
  logic [3:0] pid;

  rx_packet_sequencer dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .d_edge             (d_edge),
    .shift_strobe       (shift_strobe),
    .rcv_bit            (rcv_bit),
    .eop                (eop),
    .sync_shift_enable  (sync_shift_enable),
    .pid_shift_enable   (pid_shift_enable),
    .crc5_shift_enable  (crc5_shift_enable),
    .crc16_shift_enable (crc16_shift_enable),
    .data_shift_enable  (data_shift_enable),
    .rcving             (rcving),
    .r_error            (r_error),
    .pkt_done           (pkt_done),
    .pid                (pid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_pid;
  bit         pkt[$];
  int n_sync, n_pid, n_crc5, n_crc16, n_data, n_done;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Samples the current (pre-edge) outputs, drives one cycle of inputs, advances to the next negedge.
  task automatic cycle(input logic de, input logic st, input logic b, input logic e);
    if (st) begin
      n_sync  += int'(sync_shift_enable);
      n_pid   += int'(pid_shift_enable);
      n_crc5  += int'(crc5_shift_enable);
      n_crc16 += int'(crc16_shift_enable);
      n_data  += int'(data_shift_enable);
    end
    n_done += int'(pkt_done);
    d_edge       = de;
    shift_strobe = st;
    rcv_bit      = b;
    eop          = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) pkt.push_back(b[i]);
  endtask

  task automatic add_random_bits(input int n);
    for (int i = 0; i < n; i++) pkt.push_back(1'($urandom_range(0, 1)));
  endtask

  // Reference model: judges the whole bit stream (followed by eop) by the framing rules.
  function automatic bit model_good(inout logic [3:0] pidv, output int kind, output int payload);
    logic [7:0] sync_b, pid_b;
    kind    = 0;
    payload = 0;
    sync_b  = '0;
    pid_b   = '0;
    if (pkt.size() < 8) return 1'b0;
    for (int i = 0; i < 8; i++) sync_b[i] = pkt[i];
    if (sync_b != 8'h80) return 1'b0;
    if (pkt.size() < 16) return 1'b0;
    for (int i = 0; i < 8; i++) pid_b[i] = pkt[8+i];
    pidv    = pid_b[3:0];
    payload = pkt.size() - 16;
`ifdef PID_CHECK_EN
    if (pid_b[7:4] != ~pid_b[3:0]) return 1'b0;
`endif
    case (pid_b[3:0])
      4'h1, 4'h9, 4'hD, 4'h5: begin kind = 1; return payload == 16; end
      4'h3, 4'hB: begin
        kind = 2;
        return payload >= 16 && payload % 8 == 0 && payload <= 8200;
      end
      4'h2, 4'hA, 4'hE: begin kind = 3; return payload == 0; end
      default: return 1'b0;
    endcase
  endfunction

  // Sends pkt framed by d_edge and a two-cycle eop, then checks the outcome against the model.
  task automatic send_packet(input string name, input int max_gap, input bit merge_eop);
    logic [3:0] pidv;
    int         kind, payload;
    bit         good, merge;
    pidv = exp_pid;
    good = model_good(pidv, kind, payload);
    merge = merge_eop && (pkt.size() > 16);
    n_sync = 0; n_pid = 0; n_crc5 = 0; n_crc16 = 0; n_data = 0; n_done = 0;

    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (r_error !== 1'b0 || rcving !== 1'b1) begin
      errors++;
      $display("FAIL %s d_edge: r_error=%b rcving=%b expected 0/1", name, r_error, rcving);
    end

    for (int i = 0; i < pkt.size(); i++) begin
      if (merge && i == pkt.size() - 1)
        cycle(1'b0, 1'b1, pkt[i], 1'b1);
      else begin
        cycle(1'b0, 1'b1, pkt[i], 1'b0);
        repeat ($urandom_range(0, max_gap)) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    if (!merge) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    exp_pid = pidv;

    checks++;
    if (n_done !== int'(good)) begin
      errors++;
      $display("FAIL %s pkt_done: pulses=%0d expected %0d", name, n_done, int'(good));
    end
    checks++;
    if (r_error !== !good) begin
      errors++;
      $display("FAIL %s r_error: got %b expected %b", name, r_error, !good);
    end
    checks++;
    if (rcving !== 1'b0) begin
      errors++;
      $display("FAIL %s rcving_after: got %b expected 0", name, rcving);
    end
    checks++;
    if (pid !== exp_pid) begin
      errors++;
      $display("FAIL %s pid: got %h expected %h", name, pid, exp_pid);
    end
    if (good) begin
      checks++;
      if (n_sync !== 8 || n_pid !== 8) begin
        errors++;
        $display("FAIL %s sync/pid enables: got %0d/%0d expected 8/8", name, n_sync, n_pid);
      end
      checks++;
      if (n_crc5 !== ((kind == 1) ? 16 : 0)) begin
        errors++;
        $display("FAIL %s crc5 enable: got %0d expected %0d", name, n_crc5, (kind == 1) ? 16 : 0);
      end
      checks++;
      if (n_data !== ((kind == 2) ? payload : 0) || n_crc16 !== n_data) begin
        errors++;
        $display("FAIL %s data/crc16 enable: got %0d/%0d expected %0d", name, n_data, n_crc16,
                 (kind == 2) ? payload : 0);
      end
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0; d_edge = 0; shift_strobe = 0; rcv_bit = 0; eop = 0;
    exp_pid = 4'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sync_shift_enable, pid_shift_enable, crc5_shift_enable, crc16_shift_enable,
         data_shift_enable, rcving, r_error, pkt_done, pid} !== 12'h000) begin
      errors++;
      $display("FAIL reset outputs: rcving=%b r_error=%b pkt_done=%b pid=%h expected all 0",
               rcving, r_error, pkt_done, pid);
    end
    n_rst = 1'b1;
    idle(2);
  endtask

  task automatic test_token;
    pkt.delete(); add_byte(8'h80); add_byte(8'hE1); add_random_bits(16);
    send_packet("token_out", 2, 1'b0);
    pkt.delete(); add_byte(8'h80); add_byte(8'h69); add_random_bits(16);
    send_packet("token_in_merged", 1, 1'b1);
    pkt.delete(); add_byte(8'h80); add_byte(8'hE1); add_random_bits(15);
    send_packet("token_short", 1, 1'b0);
    pkt.delete(); add_byte(8'h80); add_byte(8'hE1); add_random_bits(17);
    send_packet("token_long", 1, 1'b0);
  endtask

  task automatic test_data;
    pkt.delete(); add_byte(8'h80); add_byte(8'hC3); add_random_bits(24);
    send_packet("data0_3bytes", 2, 1'b0);
    pkt.delete(); add_byte(8'h80); add_byte(8'h4B); add_random_bits(8);
    send_packet("data1_too_short", 1, 1'b0);
    pkt.delete(); add_byte(8'h80); add_byte(8'hC3); add_random_bits(27);
    send_packet("data0_unaligned", 1, 1'b1);
  endtask

  task automatic test_handshake;
    pkt.delete(); add_byte(8'h80); add_byte(8'hD2);
    send_packet("ack", 2, 1'b0);
    pkt.delete(); add_byte(8'h80); add_byte(8'hD2); add_random_bits(1);
    send_packet("ack_extra_strobe", 2, 1'b0);
  endtask

  task automatic test_bad_sync;
    pkt.delete(); add_byte(8'h81); add_byte(8'hE1); add_random_bits(16);
    send_packet("bad_sync", 1, 1'b0);
    idle(4);
    checks++;
    if (r_error !== 1'b1) begin
      errors++;
      $display("FAIL bad_sync sticky: r_error=%b expected 1", r_error);
    end
    pkt.delete(); add_byte(8'h80); add_byte(8'h5A);
    send_packet("after_bad_sync", 1, 1'b0);
  endtask

  task automatic test_pid_check;
    pkt.delete(); add_byte(8'h80); add_byte(8'h11); add_random_bits(16);
    send_packet("pid_11", 1, 1'b0);
  endtask

  task automatic test_async_reset;
    pkt.delete(); add_byte(8'h80); add_byte(8'hC3); add_random_bits(10);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < pkt.size(); i++) cycle(1'b0, 1'b1, pkt[i], 1'b0);
    checks++;
    if (rcving !== 1'b1 || data_shift_enable !== 1'b1) begin
      errors++;
      $display("FAIL mid_data state: rcving=%b data_en=%b expected 1/1", rcving, data_shift_enable);
    end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({sync_shift_enable, pid_shift_enable, crc5_shift_enable, crc16_shift_enable,
         data_shift_enable, rcving, r_error, pkt_done, pid} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset outputs: rcving=%b data_en=%b pid=%h expected all 0",
               rcving, data_shift_enable, pid);
    end
    exp_pid = 4'h0;
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (rcving !== 1'b0) begin
      errors++;
      $display("FAIL post_reset idle: rcving=%b expected 0", rcving);
    end
    pkt.delete(); add_byte(8'h80); add_byte(8'hC3); add_random_bits(32);
    send_packet("after_reset_data", 1, 1'b0);
  endtask

  task automatic test_overrun;
    pkt.delete(); add_byte(8'h80); add_byte(8'hC3); add_random_bits(8200);
    send_packet("data_max_8200", 0, 1'b0);
    pkt.delete(); add_byte(8'h80); add_byte(8'h4B); add_random_bits(8201);
    send_packet("data_overrun_8201", 0, 1'b1);
  endtask

  task automatic test_random;
    int lens[9] = '{0, 8, 15, 16, 17, 24, 32, 40, 45};
    logic [3:0] nib;
    logic [7:0] pid_b, sync_b;
    for (int n = 0; n < 24; n++) begin
      nib    = 4'($urandom_range(0, 15));
      pid_b  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {~nib, nib};
      sync_b = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h80;
      pkt.delete(); add_byte(sync_b); add_byte(pid_b);
      add_random_bits(lens[$urandom_range(0, 8)]);
      send_packet($sformatf("random_%0d", n), 2, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_token();
    test_data();
    test_handshake();
    test_bad_sync();
    test_pid_check();
    test_async_reset();
    test_overrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
